// File: rtl/ray_traverse_ctrl.sv
// rtl/ray_traverse_ctrl.sv - 3D DDA voxel traversal sequencer with step_update helper
module step_update #(
    parameter int W = 32
) (
    input  logic [4:0]   ix,
    input  logic [4:0]   iy,
    input  logic [4:0]   iz,
    input  logic         sx,
    input  logic         sy,
    input  logic         sz,
    input  logic [W-1:0] next_x,
    input  logic [W-1:0] next_y,
    input  logic [W-1:0] next_z,
    input  logic [W-1:0] inc_x,
    input  logic [W-1:0] inc_y,
    input  logic [W-1:0] inc_z,
    output logic [4:0]   ix_n,
    output logic [4:0]   iy_n,
    output logic [4:0]   iz_n,
    output logic [W-1:0] next_x_n,
    output logic [W-1:0] next_y_n,
    output logic [W-1:0] next_z_n,
    output logic [2:0]   face_mask,
    output logic [2:0]   primary_face_id,
    output logic         grid_exit
);
    logic         x_le_y;
    logic         x_le_z;
    logic         y_le_z;
    logic [W-1:0] m;
    logic [2:0]   at_edge;

    always_comb begin
        x_le_y = next_x <= next_y;
        x_le_z = next_x <= next_z;
        y_le_z = next_y <= next_z;
        // The primary-axis selection doubles as the minimum selection
        if (x_le_y && x_le_z) begin
            m               = next_x;
            primary_face_id = {2'b00, ~sx};
        end else if (y_le_z) begin
            m               = next_y;
            primary_face_id = {2'b01, ~sy};
        end else begin
            m               = next_z;
            primary_face_id = {2'b10, ~sz};
        end
        face_mask = {next_z == m, next_y == m, next_x == m};
        at_edge   = {sz ? (iz == 5'd31) : (iz == 5'd0),
                     sy ? (iy == 5'd31) : (iy == 5'd0),
                     sx ? (ix == 5'd31) : (ix == 5'd0)};
        grid_exit = |(face_mask & at_edge);
        ix_n      = face_mask[0] ? (sx ? ix + 5'd1 : ix - 5'd1) : ix;
        iy_n      = face_mask[1] ? (sy ? iy + 5'd1 : iy - 5'd1) : iy;
        iz_n      = face_mask[2] ? (sz ? iz + 5'd1 : iz - 5'd1) : iz;
        next_x_n  = face_mask[0] ? next_x + inc_x : next_x;
        next_y_n  = face_mask[1] ? next_y + inc_y : next_y;
        next_z_n  = face_mask[2] ? next_z + inc_z : next_z;
    end
endmodule

module ray_traverse_ctrl #(
    parameter int W         = 32,
    parameter int MAX_STEPS = 96
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [4:0]   ix0,
    input  logic [4:0]   iy0,
    input  logic [4:0]   iz0,
    input  logic         sx,
    input  logic         sy,
    input  logic         sz,
    input  logic [W-1:0] next_x0,
    input  logic [W-1:0] next_y0,
    input  logic [W-1:0] next_z0,
    input  logic [W-1:0] inc_x,
    input  logic [W-1:0] inc_y,
    input  logic [W-1:0] inc_z,
    output logic         vox_req_valid,
    input  logic         vox_req_ready,
    output logic [14:0]  vox_addr,
    input  logic         vox_rsp_valid,
    input  logic         vox_occ,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_hit,
    output logic         res_timeout,
    output logic [4:0]   res_ix,
    output logic [4:0]   res_iy,
    output logic [4:0]   res_iz,
    output logic [2:0]   res_face_id,
    output logic [2:0]   res_face_mask,
    output logic [7:0]   res_steps,
    output logic         busy
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        WAIT   = 3'd2,
        STEP   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [7:0] STEP_LIMIT = 8'(MAX_STEPS);

    state_t       state, state_n;
    logic [4:0]   cx, cy, cz;
    logic         dx, dy, dz;
    logic [W-1:0] tx, ty, tz;
    logic [W-1:0] ax, ay, az;
    logic [7:0]   steps;
    logic [2:0]   face_id;
    logic [2:0]   face_mask;
    logic         hit;
    logic         timeout;

    logic [4:0]   su_ix, su_iy, su_iz;
    logic [W-1:0] su_tx, su_ty, su_tz;
    logic [2:0]   su_mask;
    logic [2:0]   su_face;
    logic         su_exit;

    step_update #(.W(W)) u_step (
        .ix              (cx),
        .iy              (cy),
        .iz              (cz),
        .sx              (dx),
        .sy              (dy),
        .sz              (dz),
        .next_x          (tx),
        .next_y          (ty),
        .next_z          (tz),
        .inc_x           (ax),
        .inc_y           (ay),
        .inc_z           (az),
        .ix_n            (su_ix),
        .iy_n            (su_iy),
        .iz_n            (su_iz),
        .next_x_n        (su_tx),
        .next_y_n        (su_ty),
        .next_z_n        (su_tz),
        .face_mask       (su_mask),
        .primary_face_id (su_face),
        .grid_exit       (su_exit)
    );

    always_comb begin
        state_n       = state;
        start_ready   = 1'b0;
        vox_req_valid = 1'b0;
        res_valid     = 1'b0;
        busy          = 1'b1;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start_valid) state_n = LOOKUP;
            end
            LOOKUP: begin
                vox_req_valid = 1'b1;
                if (vox_req_ready) state_n = WAIT;
            end
            WAIT: begin
                if (vox_rsp_valid) state_n = vox_occ ? DONE : STEP;
            end
            STEP: begin
                if (su_exit || steps == STEP_LIMIT) state_n = DONE;
                else state_n = LOOKUP;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cx        <= '0;
            cy        <= '0;
            cz        <= '0;
            dx        <= 1'b0;
            dy        <= 1'b0;
            dz        <= 1'b0;
            tx        <= '0;
            ty        <= '0;
            tz        <= '0;
            ax        <= '0;
            ay        <= '0;
            az        <= '0;
            steps     <= '0;
            face_id   <= 3'd7;
            face_mask <= '0;
            hit       <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        cx        <= ix0;
                        cy        <= iy0;
                        cz        <= iz0;
                        dx        <= sx;
                        dy        <= sy;
                        dz        <= sz;
                        tx        <= next_x0;
                        ty        <= next_y0;
                        tz        <= next_z0;
                        ax        <= inc_x;
                        ay        <= inc_y;
                        az        <= inc_z;
                        steps     <= '0;
                        face_id   <= 3'd7;
                        face_mask <= '0;
                        hit       <= 1'b0;
                        timeout   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (vox_rsp_valid && vox_occ) hit <= 1'b1;
                end
                STEP: begin
                    // An exiting step reports its face but leaves the indices in-grid
                    if (su_exit) begin
                        face_id   <= su_face;
                        face_mask <= su_mask;
                    end else if (steps == STEP_LIMIT) begin
                        timeout <= 1'b1;
                    end else begin
                        cx        <= su_ix;
                        cy        <= su_iy;
                        cz        <= su_iz;
                        tx        <= su_tx;
                        ty        <= su_ty;
                        tz        <= su_tz;
                        face_id   <= su_face;
                        face_mask <= su_mask;
                        steps     <= steps + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign vox_addr      = {cz, cy, cx};
    assign res_hit       = hit;
    assign res_timeout   = timeout;
    assign res_ix        = cx;
    assign res_iy        = cy;
    assign res_iz        = cz;
    assign res_face_id   = face_id;
    assign res_face_mask = face_mask;
    assign res_steps     = steps;
endmodule

// File: tb/tb_ray_traverse_ctrl.sv
// tb/tb_ray_traverse_ctrl.sv - self-checking bench for ray_traverse_ctrl
module tb_ray_traverse_ctrl;
    localparam int W    = 32;
    localparam int MAXS = 4;

    typedef struct {
        logic [4:0]  x, y, z;
        logic        sx, sy, sz;
        logic [31:0] tx, ty, tz, dx, dy, dz;
    } ray_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [4:0]  ix0, iy0, iz0;
    logic        sx, sy, sz;
    logic [31:0] next_x0, next_y0, next_z0;
    logic [31:0] inc_x, inc_y, inc_z;
    logic        vox_req_valid;
    logic        vox_req_ready;
    logic [14:0] vox_addr;
    logic        vox_rsp_valid;
    logic        vox_occ;
    logic        res_valid;
    logic        res_ready;
    logic        res_hit;
    logic        res_timeout;
    logic [4:0]  res_ix, res_iy, res_iz;
    logic [2:0]  res_face_id;
    logic [2:0]  res_face_mask;
    logic [7:0]  res_steps;
    logic        busy;

    ray_traverse_ctrl #(.W(W), .MAX_STEPS(MAXS)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .ix0           (ix0),
        .iy0           (iy0),
        .iz0           (iz0),
        .sx            (sx),
        .sy            (sy),
        .sz            (sz),
        .next_x0       (next_x0),
        .next_y0       (next_y0),
        .next_z0       (next_z0),
        .inc_x         (inc_x),
        .inc_y         (inc_y),
        .inc_z         (inc_z),
        .vox_req_valid (vox_req_valid),
        .vox_req_ready (vox_req_ready),
        .vox_addr      (vox_addr),
        .vox_rsp_valid (vox_rsp_valid),
        .vox_occ       (vox_occ),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_hit       (res_hit),
        .res_timeout   (res_timeout),
        .res_ix        (res_ix),
        .res_iy        (res_iy),
        .res_iz        (res_iz),
        .res_face_id   (res_face_id),
        .res_face_mask (res_face_mask),
        .res_steps     (res_steps),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          occ [0:32767];
    logic [14:0] exp_addr [$];
    bit          exp_on   = 0;
    bit          stall    = 0;
    bit          hold_rsp = 0;
    bit          pend     = 0;
    bit          pend_occ = 0;
    int          rsp_wait = 0;

    logic        exp_hit, exp_tmo;
    logic [4:0]  exp_x, exp_y, exp_z;
    logic [2:0]  exp_fid, exp_mask;
    int          exp_steps;

    logic        got_hit, got_tmo;
    logic [4:0]  got_x, got_y, got_z;
    logic [2:0]  got_fid, got_mask;
    int          got_steps;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference traversal: walk the voxel grid voxel by voxel with plain arithmetic
    task automatic model(input ray_t r);
        logic [4:0]  c [3];
        logic [31:0] t [3];
        logic [31:0] d [3];
        logic        s [3];
        logic [31:0] m;
        logic [2:0]  mk;
        logic [2:0]  pf;
        bit          out;
        int          n;
        c[0] = r.x;  c[1] = r.y;  c[2] = r.z;
        t[0] = r.tx; t[1] = r.ty; t[2] = r.tz;
        d[0] = r.dx; d[1] = r.dy; d[2] = r.dz;
        s[0] = r.sx; s[1] = r.sy; s[2] = r.sz;
        exp_addr.delete();
        exp_hit = 0; exp_tmo = 0; exp_fid = 3'd7; exp_mask = 3'd0; n = 0;
        forever begin
            exp_addr.push_back({c[2], c[1], c[0]});
            if (occ[{c[2], c[1], c[0]}]) begin
                exp_hit = 1;
                break;
            end
            m = t[0];
            if (t[1] < m) m = t[1];
            if (t[2] < m) m = t[2];
            mk  = 3'd0;
            pf  = 3'd7;
            out = 0;
            for (int a = 2; a >= 0; a--) begin
                if (t[a] == m) begin
                    mk[a] = 1'b1;
                    pf = 3'(2 * a + (s[a] ? 0 : 1));
                    if ((s[a] && c[a] == 5'd31) || (!s[a] && c[a] == 5'd0)) out = 1;
                end
            end
            if (out) begin
                exp_fid = pf; exp_mask = mk;
                break;
            end
            if (n == MAXS) begin
                exp_tmo = 1;
                break;
            end
            for (int a = 0; a < 3; a++) begin
                if (mk[a]) begin
                    c[a] = s[a] ? c[a] + 5'd1 : c[a] - 5'd1;
                    t[a] = t[a] + d[a];
                end
            end
            exp_fid = pf; exp_mask = mk; n++;
        end
        exp_x = c[0]; exp_y = c[1]; exp_z = c[2]; exp_steps = n;
    endtask

    task automatic set_occ(input int px, input int py, input int pz);
        for (int i = 0; i < 32768; i++) occ[i] = 0;
        if (px >= 0) occ[{5'(pz), 5'(py), 5'(px)}] = 1;
    endtask

    // Voxel memory responder: accepts lookups and answers with optional latency
    initial begin
        vox_req_ready = 0; vox_rsp_valid = 0; vox_occ = 0;
        forever begin
            @(negedge clk);
            vox_rsp_valid = 0;
            vox_occ       = 0;
            if (pend && !hold_rsp) begin
                if (rsp_wait == 0) begin
                    vox_rsp_valid = 1;
                    vox_occ       = pend_occ;
                    pend          = 0;
                end else begin
                    rsp_wait--;
                end
            end
            vox_req_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (vox_req_valid && vox_req_ready && !rst) begin
                if (exp_addr.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL vox_addr_unexpected: got %0h expected no request", vox_addr);
                end else begin
                    chk("vox_addr", 32'(vox_addr), 32'(exp_addr.pop_front()));
                end
                pend     = 1;
                pend_occ = occ[vox_addr];
                rsp_wait = stall ? int'($urandom_range(0, 3)) : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("busy_vs_start_ready", 32'(busy), 32'(!start_ready));
            if (res_valid && exp_on) begin
                chk("res_hit", 32'(res_hit), 32'(exp_hit));
                chk("res_timeout", 32'(res_timeout), 32'(exp_tmo));
                chk("res_ix", 32'(res_ix), 32'(exp_x));
                chk("res_iy", 32'(res_iy), 32'(exp_y));
                chk("res_iz", 32'(res_iz), 32'(exp_z));
                chk("res_face_id", 32'(res_face_id), 32'(exp_fid));
                chk("res_face_mask", 32'(res_face_mask), 32'(exp_mask));
                chk("res_steps", 32'(res_steps), 32'(exp_steps));
                chk("no_req_in_done", 32'(vox_req_valid), 32'd0);
            end
        end
    end

    task automatic launch(input ray_t r);
        int k;
        @(negedge clk);
        ix0 = r.x; iy0 = r.y; iz0 = r.z;
        sx = r.sx; sy = r.sy; sz = r.sz;
        next_x0 = r.tx; next_y0 = r.ty; next_z0 = r.tz;
        inc_x = r.dx; inc_y = r.dy; inc_z = r.dz;
        start_valid = 1;
        k = 0;
        while (!start_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("start_ready_before_start", 32'(start_ready), 32'd1);
        @(negedge clk);
        start_valid = 0;
        chk("req_one_cycle_after_start", 32'(vox_req_valid), 32'd1);
    endtask

    task automatic run_ray(input ray_t r);
        int k;
        model(r);
        exp_on = 1;
        launch(r);
        k = 0;
        while (!res_valid && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("res_valid_within_budget", 32'(res_valid), 32'd1);
        got_hit = res_hit; got_tmo = res_timeout;
        got_x = res_ix; got_y = res_iy; got_z = res_iz;
        got_fid = res_face_id; got_mask = res_face_mask; got_steps = int'(res_steps);
        if (stall) repeat ($urandom_range(0, 3)) @(negedge clk);
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        chk("idle_after_res_handshake", 32'(start_ready), 32'd1);
        chk("res_valid_dropped", 32'(res_valid), 32'd0);
        chk("all_lookups_issued", 32'(exp_addr.size()), 32'd0);
        exp_on = 0;
    endtask

    task automatic lit(input string name, input logic h, input logic t, input int x, input int y,
                       input int z, input int fid, input int mask, input int steps);
        chk({name, "_hit"}, 32'(got_hit), 32'(h));
        chk({name, "_timeout"}, 32'(got_tmo), 32'(t));
        chk({name, "_pos"}, {17'd0, got_z, got_y, got_x}, 32'(x + 32 * y + 1024 * z));
        chk({name, "_face_id"}, 32'(got_fid), 32'(fid));
        chk({name, "_face_mask"}, 32'(got_mask), 32'(mask));
        chk({name, "_steps"}, 32'(got_steps), 32'(steps));
    endtask

    ray_t r1, r2, r3, r4, r5, r6;

    initial begin
        rst = 1; start_valid = 0; res_ready = 0;
        ix0 = 0; iy0 = 0; iz0 = 0; sx = 0; sy = 0; sz = 0;
        next_x0 = 0; next_y0 = 0; next_z0 = 0; inc_x = 0; inc_y = 0; inc_z = 0;
        r1 = '{5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 32'd10, 32'd20, 32'd30, 32'd1, 32'd1, 32'd1};
        r2 = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 32'd1, 32'd100, 32'd100, 32'd1, 32'd1, 32'd1};
        r3 = '{5'd10, 5'd10, 5'd10, 1'b0, 1'b0, 1'b0, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4};
        r4 = '{5'd31, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 32'd1, 32'd50, 32'd50, 32'd10, 32'd10, 32'd10};
        r5 = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 32'd1, 32'd100, 32'd100, 32'd1, 32'd1, 32'd1};
        r6 = '{5'd3, 5'd20, 5'd15, 1'b1, 1'b0, 1'b0, 32'd5, 32'd3, 32'd7, 32'd4, 32'd4, 32'd4};
        repeat (3) @(negedge clk);
        chk("reset_start_ready", 32'(start_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_req_valid", 32'(vox_req_valid), 32'd0);
        chk("reset_res_valid", 32'(res_valid), 32'd0);
        chk("reset_face_id", 32'(res_face_id), 32'd7);
        chk("reset_steps", 32'(res_steps), 32'd0);
        rst = 0;

        for (int pass = 0; pass < 2; pass++) begin
            stall = (pass == 1);
            set_occ(5, 5, 5);   run_ray(r1); lit("start_hit", 1, 0, 5, 5, 5, 7, 0, 0);
            set_occ(3, 0, 0);   run_ray(r2); lit("plus_x_hit", 1, 0, 3, 0, 0, 0, 1, 3);
            set_occ(9, 9, 9);   run_ray(r3); lit("tie_xyz", 1, 0, 9, 9, 9, 1, 7, 1);
            set_occ(-1, 0, 0);  run_ray(r4); lit("grid_exit", 0, 0, 31, 2, 2, 0, 1, 0);
            set_occ(-1, 0, 0);  run_ray(r5); lit("timeout", 0, 1, 4, 0, 0, 0, 1, 4);
            set_occ(4, 18, 14); run_ray(r6); lit("mixed_axes", 1, 0, 4, 18, 14, 3, 6, 3);
        end
        stall = 0;

        // Reset while a lookup is outstanding; its response arrives after reset
        set_occ(3, 0, 0);
        model(r2);
        hold_rsp = 1;
        launch(r2);
        for (int k = 0; k < 50 && !pend; k++) @(negedge clk);
        chk("reset_test_req_accepted", 32'(pend), 32'd1);
        @(negedge clk);
        chk("reset_test_in_wait", {30'd0, busy, vox_req_valid}, 32'd2);
        rst = 1;
        @(negedge clk);
        rst = 0;
        exp_addr.delete();
        hold_rsp = 0;
        repeat (2) @(negedge clk);
        chk("late_rsp_delivered", 32'(pend), 32'd0);
        chk("post_reset_start_ready", 32'(start_ready), 32'd1);
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_req_valid", 32'(vox_req_valid), 32'd0);
        chk("post_reset_res_valid", 32'(res_valid), 32'd0);
        chk("post_reset_face_id", 32'(res_face_id), 32'd7);
        chk("post_reset_addr", 32'(vox_addr), 32'd0);
        set_occ(9, 9, 9); run_ray(r3); lit("after_reset", 1, 0, 9, 9, 9, 1, 7, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary expected completion");
        $fatal(1);
    end
endmodule

// File: doc/ray_traverse_ctrl.md
# ray_traverse_ctrl

Sequencing controller for the voxel-stepping datapath of the 3D DDA raytracer. It accepts one ray setup, runs the traversal loop, and terminates on a hit, a grid exit or a step-count timeout. Each loop iteration looks up occupancy of the current voxel over a request/response port, chooses the stepping axes, and advances indices and timers through an internal `step_update` instance. It sits between the ray-setup stage and the shading/result stage and serves one ray at a time.

## Interface

- W, 32, timer/increment width; passed to the internal `step_update`.
- MAX_STEPS, 96, maximum voxel steps per ray; legal range 1..255.

- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  ray setup valid.
- start_ready  out  1  high only in IDLE.
- ix0, iy0, iz0  in  5 each  start voxel.
- sx, sy, sz  in  1 each  step sign per axis: 1 = +1, 0 = −1.
- next_x0, next_y0, next_z0  in  W each  initial axis timers.
- inc_x, inc_y, inc_z  in  W each  per-step timer increments.
- vox_req_valid  out  1  occupancy lookup request.
- vox_req_ready  in  1  lookup accepted.
- vox_addr  out  15  {iz, iy, ix} of the current voxel.
- vox_rsp_valid  in  1  lookup response.
- vox_occ  in  1  1 = voxel occupied; sampled with vox_rsp_valid.
- res_valid  out  1  result valid; held until accepted.
- res_ready  in  1  result consumer ready.
- res_hit  out  1  ray hit an occupied voxel.
- res_timeout  out  1  traversal stopped at MAX_STEPS.
- res_ix, res_iy, res_iz  out  5 each  final voxel.
- res_face_id  out  3  0=X+, 1=X−, 2=Y+, 3=Y−, 4=Z+, 5=Z−; 7 = hit in the start voxel.
- res_face_mask  out  3  axes stepped on the final step: [0]=X, [1]=Y, [2]=Z.
- res_steps  out  8  steps taken.
- busy  out  1  high in every state except IDLE.

## Operation

- **States:** IDLE, LOOKUP, WAIT, STEP, DONE.
- **IDLE:** start_ready=1.
  - On start handshake, latch the ray setup, the signs and the increments.
  - Clear the step count; set the last-face register to id 7, mask 0.
  - Next state: LOOKUP.
- **LOOKUP:** vox_req_valid=1 and vox_addr is held stable until vox_req_ready; then go to WAIT.
- **WAIT:** wait for vox_rsp_valid. One request outstanding at most.
  - vox_rsp_valid is ignored in every other state.
  - vox_occ=1: go to DONE with hit. The face outputs are the last-face register.
  - vox_occ=0: go to STEP.
- **Axis choice in STEP:**
  - m = min(next_x, next_y, next_z), unsigned.
  - step_mask = all axes whose timer equals m.
  - primary = X if x≤y and x≤z; else Y if y≤z; else Z.
- **STEP evaluation, in priority order:**
  1. **Grid exit:** some axis in step_mask has index 31 with sign +, or index 0 with sign −. Go to DONE with miss. Indices stay at the last in-grid voxel; the face outputs are those of the exiting step.
  2. **Timeout:** step count == MAX_STEPS. Go to DONE with res_timeout=1 and res_hit=0.
  3. **Step:** otherwise register the `step_update` outputs (indices, timers, face_mask, primary_face_id), increment the step count, and go to LOOKUP.
- **Timer arithmetic:** timer addition wraps modulo 2^W. The ray setup stage guarantees no overflow within MAX_STEPS.
- **DONE:** res_valid=1 with all res_* fields stable. On res_ready, go to IDLE.
- **Start while busy:** not accepted (start_ready=0).
- **Reset, including mid-operation:** go to IDLE. All outputs return to 0 except start_ready=1 and res_face_id=7. An in-flight lookup response is dropped.

## Timing

- Start handshake at cycle t: vox_req_valid is high at t+1.
- Per-voxel iteration with vox_req_ready=1 and a response one cycle after the request: LOOKUP t, WAIT t+1, STEP t+2, next LOOKUP t+3. That is 3 cycles per voxel.
- res_valid rises the cycle after the terminating WAIT or STEP cycle.
- DONE→IDLE takes 1 cycle after the res_ready handshake. The earliest next start is the following cycle.
- Back-pressure on vox_req_ready, vox_rsp_valid or res_ready stalls the FSM indefinitely with no state loss.

## Test plan

- **Start voxel occupied:** start (5,5,5), vox_occ=1 on the first lookup → res_hit=1, res_steps=0, res_face_id=7, res_face_mask=0, voxel (5,5,5).
- **Hit after +X stepping:** start (0,0,0), sx=1, next_x=1, next_y=next_z=100, inc_x=1; occupied only at ix=3 → hit at (3,0,0), res_steps=3, res_face_id=0, res_face_mask=3'b001.
- **Tie on all three axes:** timers all 4, signs all 0, start (10,10,10); occupied at (9,9,9) → single step, res_face_mask=3'b111, res_face_id=1 (primary X).
- **Grid exit:** start (31,2,2), sx=1, X timer smallest, no occupancy → miss, res_ix=31, res_steps=0, res_face_id=0, res_timeout=0.
- **Timeout:** MAX_STEPS=4, empty grid, long ray inside the grid → res_timeout=1, res_hit=0, res_steps=4.
- **Reset mid-WAIT, with back-pressure:**
  - Assert rst while in WAIT, then deliver a late vox_rsp_valid → it is ignored; IDLE with start_ready=1; a new ray completes correctly.
  - Randomized stalls on vox_req_ready and res_ready → results identical to the zero-stall run.
